axis_rr_arbiter: RTL and testbench
==================================

# axis_rr_arbiter

Round-robin arbiter that shares one AXI-stream output between COUNT input streams. Each grant lasts up to BURST transfers or until the granted source goes idle, then the grant rotates to the next requester. The block sits in front of a shared sink, such as a register stage, a small FIFO or a throttle, when several producers feed it. The current owner's index is exported alongside the data.

## Interface
- WIDTH, 8, data width of every stream.
- COUNT, 4, number of input streams; valid range 2..16.
- BURST, 4, maximum transfers per grant; valid range 1..256.
- CW, $clog2(COUNT), width of channel index (derived, not overridden).
- clock  input  1  single clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- idata  input  COUNT*WIDTH  input data; stream k occupies bits [k*WIDTH +: WIDTH].
- ivalid  input  COUNT  per-stream valid.
- iready  output  COUNT  per-stream ready; at most one bit high.
- odata  output  WIDTH  output data.
- ovalid  output  1  output valid.
- oready  input  1  output ready.
- ochannel  output  CW  index of the stream currently granted; meaningful while ovalid is high.

## Operation
- Transfer on a port happens at a rising edge where xvalid and xready are both high.
- State registers:
  - busy (1 bit, IDLE/GRANT)
  - grant (CW bits)
  - next (CW bits, round-robin pointer)
  - count (enough bits to hold BURST-1)
- IDLE (busy=0):
  - Outputs: iready=0, ovalid=0.
  - If any ivalid is high, pick the first k with ivalid[k]=1, searching next, next+1, …, COUNT-1, 0, …, next-1.
  - Load grant=k, count=0, busy=1.
  - If no ivalid is high, stay in IDLE.
- GRANT (busy=1), combinational paths:
  - odata=idata[grant]
  - ovalid=ivalid[grant]
  - iready[grant]=oready; all other iready bits 0
  - ochannel=grant
- GRANT, transfer (ivalid[grant] && oready):
  - If count==BURST-1: go to IDLE, next=grant+1 (wraps COUNT-1→0).
  - Otherwise: count=count+1.
- GRANT, ivalid[grant]=0: go to IDLE, next=grant+1. A stalled source (ivalid=1, oready=0) keeps the grant indefinitely. No grant change ever occurs while ovalid=1 without a transfer, so AXI-stream stability is preserved.
- ochannel holds the last grant while in IDLE.
- BURST=1: every transfer ends the grant.
- COUNT not a power of two: next and the search index wrap at COUNT-1, never at 2^CW-1.
- ivalid bits of non-granted streams are ignored and never produce iready.

## Timing
- Reset values: busy=0, grant=0, next=0, count=0. Hence iready=0, ovalid=0, ochannel=0. odata is don't-care.
- Reset asserted mid-grant returns the block to IDLE immediately (async). No transfer completes in that cycle.
- Arbitration latency: 1 cycle. ivalid rising at edge N gives ovalid high after edge N+1.
- Every grant change costs one IDLE bubble cycle.
- Sustained throughput for a single continuously valid source is BURST/(BURST+1).
- Data path is combinational from idata to odata: zero latency within a grant.
- Simultaneous requests are resolved purely by the next pointer. Starvation bound for any requester: (COUNT-1)*(BURST+1) cycles plus sink stalls.

## Test plan
- Reset, then hold ivalid=0 → iready=0, ovalid=0, ochannel=0 for 10 cycles. Assert reset mid-burst → ovalid drops the same cycle; first grant afterwards goes to stream 0.
- COUNT=4, BURST=4, only stream 2 valid with data 0x10,0x11,… and oready=1 → outputs 0x10–0x13 on ochannel=2, then 1 bubble, then 0x14–0x17. 8 transfers in 10 cycles.
- All four streams valid continuously, oready=1 → ochannel sequence 0,0,0,0,(bubble),1,1,1,1,(bubble),2…,3…,0… with no reordering within a stream.
- Stream 1 granted, oready=0 for 6 cycles → ovalid=1 and odata stable, count frozen, iready all 0. Release oready → burst resumes.
- Stream 3 granted, drops ivalid after 2 transfers while stream 0 is valid → IDLE for 1 cycle, then grant to stream 0 (wrap 3→0).
- COUNT=3, BURST=1, all valid → ochannel 0,1,2,0,1,2 with one bubble between each.

Source files
------------

// File: rtl/axis_rr_arbiter.sv
// Round-robin AXI-stream arbiter: COUNT inputs share one output.
// Ports: clock, reset (async high); idata/ivalid/iready per-stream inputs;
//   odata/ovalid/oready shared output; ochannel = index of granted stream.
module axis_rr_arbiter #(
  parameter int WIDTH = 8,
  parameter int COUNT = 4,
  parameter int BURST = 4,
  localparam int CW = $clog2(COUNT)
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [COUNT*WIDTH-1:0] idata,
  input  logic [COUNT-1:0]       ivalid,
  output logic [COUNT-1:0]       iready,
  output logic [WIDTH-1:0]       odata,
  output logic                   ovalid,
  input  logic                   oready,
  output logic [CW-1:0]          ochannel
);

  localparam int NW = (BURST > 1) ? $clog2(BURST) : 1;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  state_e        busy_q, busy_d;
  logic [CW-1:0] grant_q, grant_d;
  logic [CW-1:0] next_q, next_d;
  logic [NW-1:0] count_q, count_d;

  logic [CW-1:0] pick;
  logic          found;
  logic [CW-1:0] grant_inc;
  int            sj;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      busy_q  <= IDLE;
      grant_q <= '0;
      next_q  <= '0;
      count_q <= '0;
    end else begin
      busy_q  <= busy_d;
      grant_q <= grant_d;
      next_q  <= next_d;
      count_q <= count_d;
    end
  end

  // Search starts at the pointer and wraps at COUNT-1, not 2^CW-1.
  always_comb begin
    pick  = '0;
    found = 1'b0;
    sj    = 0;
    for (int i = 0; i < COUNT; i++) begin
      sj = int'(next_q) + i;
      if (sj >= COUNT) sj = sj - COUNT;
      if (!found && ivalid[sj]) begin
        found = 1'b1;
        pick  = CW'(sj);
      end
    end
  end

  assign grant_inc = (grant_q == CW'(COUNT - 1)) ? '0 : grant_q + 1'b1;

  always_comb begin
    busy_d  = busy_q;
    grant_d = grant_q;
    next_d  = next_q;
    count_d = count_q;
    unique case (busy_q)
      IDLE: begin
        if (found) begin
          busy_d  = GRANT;
          grant_d = pick;
          count_d = '0;
        end
      end
      GRANT: begin
        if (!ivalid[grant_q]) begin
          busy_d = IDLE;
          next_d = grant_inc;
        end else if (oready) begin
          if (count_q == NW'(BURST - 1)) begin
            busy_d = IDLE;
            next_d = grant_inc;
          end else begin
            count_d = count_q + 1'b1;
          end
        end
      end
      default: busy_d = IDLE;
    endcase
  end

  always_comb begin
    iready = '0;
    ovalid = 1'b0;
    odata  = idata[grant_q*WIDTH +: WIDTH];
    if (busy_q == GRANT) begin
      iready[grant_q] = oready;
      ovalid          = ivalid[grant_q];
    end
  end

  assign ochannel = grant_q;

endmodule

// File: tb/tb_axis_rr_arbiter.sv
// Self-checking bench for axis_rr_arbiter.
// Two instances: COUNT=4/BURST=4 and COUNT=3/BURST=1.
module tb_axis_rr_arbiter;

  logic        clock;
  logic        reset;
  logic [31:0] idata;
  logic [3:0]  ivalid;
  logic [3:0]  iready;
  logic [7:0]  odata;
  logic        ovalid;
  logic        oready;
  logic [1:0]  ochannel;

  logic [23:0] idata3;
  logic [2:0]  ivalid3;
  logic [2:0]  iready3;
  logic [7:0]  odata3;
  logic        ovalid3;
  logic        oready3;
  logic [1:0]  ochannel3;

  logic [7:0] src[4];
  logic [7:0] src3[3];

  int checks;
  int failures;

  typedef struct {
    logic [3:0] iv;
    logic       rdy;
    logic       v;
    logic [3:0] ch;
    logic [7:0] d;
    logic [3:0] ir;
  } exp_t;

  exp_t q[$];

  axis_rr_arbiter #(.WIDTH(8), .COUNT(4), .BURST(4)) u_dut (
    .clock(clock), .reset(reset),
    .idata(idata), .ivalid(ivalid), .iready(iready),
    .odata(odata), .ovalid(ovalid), .oready(oready),
    .ochannel(ochannel)
  );

  axis_rr_arbiter #(.WIDTH(8), .COUNT(3), .BURST(1)) u_dut3 (
    .clock(clock), .reset(reset),
    .idata(idata3), .ivalid(ivalid3), .iready(iready3),
    .odata(odata3), .ovalid(ovalid3), .oready(oready3),
    .ochannel(ochannel3)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic void push(logic [3:0] iv, logic rdy, logic v,
                               logic [3:0] ch, logic [7:0] d,
                               logic [3:0] ir);
    exp_t e;
    e.iv = iv; e.rdy = rdy; e.v = v;
    e.ch = ch; e.d = d; e.ir = ir;
    q.push_back(e);
  endfunction

  task automatic pack();
    idata  = {src[3], src[2], src[1], src[0]};
    idata3 = {src3[2], src3[1], src3[0]};
  endtask

  task automatic test_reset();
    oready  = 1'b1;
    ivalid  = '0;
    oready3 = 1'b1;
    ivalid3 = '0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clock);
      checks++;
      if (ovalid !== 1'b0 || iready !== 4'd0 || ochannel !== 2'd0) begin
        failures++;
        $display("FAIL reset_idle c%0d: ovalid=%b iready=%b ch=%0d want 0/0000/0",
                 c, ovalid, iready, ochannel);
      end
      checks++;
      if (ovalid3 !== 1'b0 || iready3 !== 3'd0 || ochannel3 !== 2'd0) begin
        failures++;
        $display("FAIL reset_idle3 c%0d: ovalid=%b iready=%b ch=%0d want 0/000/0",
                 c, ovalid3, iready3, ochannel3);
      end
    end
    @(posedge clock); #1;
  endtask

  task automatic test_single_stream();
    logic [3:0] hs;
    exp_t e;
    src[2] = 8'h10;
    pack();
    push(4'b0100, 1, 0, 0, 0, 4'b0000);
    for (int n = 0; n < 4; n++)
      push(4'b0100, 1, 1, 2, 8'h10 + 8'(n), 4'b0100);
    push(4'b0100, 1, 0, 2, 0, 4'b0000);
    for (int n = 4; n < 8; n++)
      push(4'b0100, 1, 1, 2, 8'h10 + 8'(n), 4'b0100);
    while (q.size() > 0) begin
      e = q.pop_front();
      ivalid = e.iv;
      oready = e.rdy;
      @(negedge clock);
      checks++;
      if (ovalid !== e.v || {2'b0, ochannel} !== e.ch || iready !== e.ir) begin
        failures++;
        $display("FAIL single: v=%b ch=%0d ir=%b want v=%b ch=%0d ir=%b",
                 ovalid, ochannel, iready, e.v, e.ch, e.ir);
      end
      if (e.v) begin
        checks++;
        if (odata !== e.d) begin
          failures++;
          $display("FAIL single_data: got %h want %h", odata, e.d);
        end
      end
      hs = iready & ivalid;
      @(posedge clock); #1;
      for (int k = 0; k < 4; k++) if (hs[k]) src[k]++;
      pack();
    end
    ivalid = '0;
  endtask

  task automatic test_reset_midburst();
    src[2] = 8'h30;
    pack();
    ivalid = 4'b0100;
    oready = 1'b1;
    @(negedge clock);
    @(posedge clock); #1;
    @(negedge clock);
    checks++;
    if (ovalid !== 1'b1 || ochannel !== 2'd2 || odata !== 8'h30) begin
      failures++;
      $display("FAIL midburst_pre: v=%b ch=%0d d=%h want 1/2/30",
               ovalid, ochannel, odata);
    end
    @(posedge clock); #1;
    src[2]++;
    pack();
    #2 reset = 1'b1;
    #1;
    checks++;
    if (ovalid !== 1'b0 || iready !== 4'd0 || ochannel !== 2'd0) begin
      failures++;
      $display("FAIL midburst_reset: v=%b ir=%b ch=%0d want 0/0000/0",
               ovalid, iready, ochannel);
    end
    ivalid = '0;
    @(posedge clock); #1;
    reset = 1'b0;
  endtask

  task automatic test_round_robin();
    logic [3:0] hs;
    logic [3:0] prev;
    logic [7:0] cnt[4];
    exp_t e;
    int s;
    for (int k = 0; k < 4; k++) begin
      src[k] = 8'(k * 'h40);
      cnt[k] = 8'(k * 'h40);
    end
    pack();
    prev = 0;
    for (int g = 0; g < 5; g++) begin
      s = g % 4;
      push(4'b1111, 1, 0, prev, 0, 4'b0000);
      for (int n = 0; n < 4; n++) begin
        push(4'b1111, 1, 1, 4'(s), cnt[s], 4'(1 << s));
        cnt[s]++;
      end
      prev = 4'(s);
    end
    while (q.size() > 0) begin
      e = q.pop_front();
      ivalid = e.iv;
      oready = e.rdy;
      @(negedge clock);
      checks++;
      if (ovalid !== e.v || {2'b0, ochannel} !== e.ch || iready !== e.ir) begin
        failures++;
        $display("FAIL rr: v=%b ch=%0d ir=%b want v=%b ch=%0d ir=%b",
                 ovalid, ochannel, iready, e.v, e.ch, e.ir);
      end
      if (e.v) begin
        checks++;
        if (odata !== e.d) begin
          failures++;
          $display("FAIL rr_data: got %h want %h", odata, e.d);
        end
      end
      hs = iready & ivalid;
      @(posedge clock); #1;
      for (int k = 0; k < 4; k++) if (hs[k]) src[k]++;
      pack();
    end
    ivalid = '0;
  endtask

  task automatic test_stall();
    logic [3:0] hs;
    exp_t e;
    src[1] = 8'h80;
    pack();
    push(4'b0010, 1, 0, 0, 0, 4'b0000);
    push(4'b0010, 1, 1, 1, 8'h80, 4'b0010);
    for (int c = 0; c < 6; c++)
      push(4'b0010, 0, 1, 1, 8'h81, 4'b0000);
    for (int n = 1; n < 4; n++)
      push(4'b0010, 1, 1, 1, 8'h80 + 8'(n), 4'b0010);
    push(4'b0000, 1, 0, 1, 0, 4'b0000);
    while (q.size() > 0) begin
      e = q.pop_front();
      ivalid = e.iv;
      oready = e.rdy;
      @(negedge clock);
      checks++;
      if (ovalid !== e.v || {2'b0, ochannel} !== e.ch || iready !== e.ir) begin
        failures++;
        $display("FAIL stall: v=%b ch=%0d ir=%b want v=%b ch=%0d ir=%b",
                 ovalid, ochannel, iready, e.v, e.ch, e.ir);
      end
      if (e.v) begin
        checks++;
        if (odata !== e.d) begin
          failures++;
          $display("FAIL stall_data: got %h want %h", odata, e.d);
        end
      end
      hs = iready & ivalid;
      @(posedge clock); #1;
      for (int k = 0; k < 4; k++) if (hs[k]) src[k]++;
      pack();
    end
    ivalid = '0;
  endtask

  task automatic test_drop();
    logic [3:0] hs;
    exp_t e;
    src[3] = 8'hC0;
    src[0] = 8'h20;
    pack();
    push(4'b1001, 1, 0, 1, 0, 4'b0000);
    push(4'b1001, 1, 1, 3, 8'hC0, 4'b1000);
    push(4'b1001, 1, 1, 3, 8'hC1, 4'b1000);
    push(4'b0001, 1, 0, 3, 0, 4'b1000);
    push(4'b0001, 1, 0, 3, 0, 4'b0000);
    for (int n = 0; n < 4; n++)
      push(4'b0001, 1, 1, 0, 8'h20 + 8'(n), 4'b0001);
    while (q.size() > 0) begin
      e = q.pop_front();
      ivalid = e.iv;
      oready = e.rdy;
      @(negedge clock);
      checks++;
      if (ovalid !== e.v || {2'b0, ochannel} !== e.ch || iready !== e.ir) begin
        failures++;
        $display("FAIL drop: v=%b ch=%0d ir=%b want v=%b ch=%0d ir=%b",
                 ovalid, ochannel, iready, e.v, e.ch, e.ir);
      end
      if (e.v) begin
        checks++;
        if (odata !== e.d) begin
          failures++;
          $display("FAIL drop_data: got %h want %h", odata, e.d);
        end
      end
      hs = iready & ivalid;
      @(posedge clock); #1;
      for (int k = 0; k < 4; k++) if (hs[k]) src[k]++;
      pack();
    end
    ivalid = '0;
  endtask

  task automatic test_burst1();
    logic [2:0] hs;
    logic [3:0] prev;
    logic [7:0] cnt[3];
    exp_t e;
    int s;
    for (int k = 0; k < 3; k++) begin
      src3[k] = 8'(k * 'h10);
      cnt[k]  = 8'(k * 'h10);
    end
    pack();
    prev = 0;
    for (int g = 0; g < 6; g++) begin
      s = g % 3;
      push(4'b0111, 1, 0, prev, 0, 4'b0000);
      push(4'b0111, 1, 1, 4'(s), cnt[s], 4'(1 << s));
      cnt[s]++;
      prev = 4'(s);
    end
    while (q.size() > 0) begin
      e = q.pop_front();
      ivalid3 = e.iv[2:0];
      oready3 = e.rdy;
      @(negedge clock);
      checks++;
      if (ovalid3 !== e.v || {2'b0, ochannel3} !== e.ch ||
          {1'b0, iready3} !== e.ir) begin
        failures++;
        $display("FAIL burst1: v=%b ch=%0d ir=%b want v=%b ch=%0d ir=%b",
                 ovalid3, ochannel3, iready3, e.v, e.ch, e.ir);
      end
      if (e.v) begin
        checks++;
        if (odata3 !== e.d) begin
          failures++;
          $display("FAIL burst1_data: got %h want %h", odata3, e.d);
        end
      end
      hs = iready3 & ivalid3;
      @(posedge clock); #1;
      for (int k = 0; k < 3; k++) if (hs[k]) src3[k]++;
      pack();
    end
    ivalid3 = '0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    ivalid   = '0;
    oready   = 1'b0;
    ivalid3  = '0;
    oready3  = 1'b0;
    for (int k = 0; k < 4; k++) src[k] = '0;
    for (int k = 0; k < 3; k++) src3[k] = '0;
    pack();
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    test_reset();
    test_single_stream();
    test_reset_midburst();
    test_round_robin();
    test_stall();
    test_drop();
    test_burst1();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
